// File: rtl/apb3_master_bridge.sv
// APB3 initiator: turns a valid/ready command stream into single APB3 transfers
// with a valid/ready response. Optional ACCESS timeout via APB3_MASTER_TIMEOUT_EN.
module apb3_master_bridge #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERROR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("apb3_master_bridge: TIMEOUT_CYCLES must be >= 2");
   end

   state_t                state_r, state_s;
   logic                  cmd_ready_s, busy_s, psel_s, penable_s, pwrite_s;
   logic                  rsp_valid_s, rsp_err_s, rsp_timeout_s;
   logic [ADDR_WIDTH-1:0] paddr_s;
   logic [DATA_WIDTH-1:0] pwdata_s, rsp_rdata_s;

`ifdef APB3_MASTER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_r, cnt_s;
`endif

   // Next-state and next-value logic for every registered output.
   always_comb begin
      state_s       = state_r;
      cmd_ready_s   = 1'b0;
      psel_s        = 1'b0;
      penable_s     = 1'b0;
      paddr_s       = PADDR;
      pwrite_s      = PWRITE;
      pwdata_s      = PWDATA;
      rsp_valid_s   = rsp_valid;
      rsp_rdata_s   = rsp_rdata;
      rsp_err_s     = rsp_err;
      rsp_timeout_s = rsp_timeout;
`ifdef APB3_MASTER_TIMEOUT_EN
      cnt_s         = cnt_r;
`endif
      case (state_r)
         IDLE: begin
            // cmd_ready comes up one cycle after reset release, then tracks IDLE.
            if (cmd_valid && cmd_ready) begin
               state_s     = SETUP;
               psel_s      = 1'b1;
               paddr_s     = cmd_addr;
               pwrite_s    = cmd_write;
               pwdata_s    = cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}};
               cmd_ready_s = 1'b0;
            end else begin
               state_s     = IDLE;
               cmd_ready_s = 1'b1;
            end
         end
         SETUP: begin
            state_s   = ACCESS;
            psel_s    = 1'b1;
            penable_s = 1'b1;
`ifdef APB3_MASTER_TIMEOUT_EN
            cnt_s     = {CNT_W{1'b0}};
`endif
         end
         ACCESS: begin
            if (PREADY) begin
               state_s       = RESP;
               rsp_valid_s   = 1'b1;
               rsp_rdata_s   = PWRITE ? {DATA_WIDTH{1'b0}} : PRDATA;
               rsp_err_s     = PSLVERROR;
               rsp_timeout_s = 1'b0;
`ifdef APB3_MASTER_TIMEOUT_EN
            end else if (cnt_r == CNT_LIMIT) begin
               state_s       = RESP;
               rsp_valid_s   = 1'b1;
               rsp_rdata_s   = {DATA_WIDTH{1'b0}};
               rsp_err_s     = 1'b1;
               rsp_timeout_s = 1'b1;
`endif
            end else begin
               psel_s    = 1'b1;
               penable_s = 1'b1;
`ifdef APB3_MASTER_TIMEOUT_EN
               cnt_s     = cnt_r + CNT_W'(1);
`endif
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_s     = IDLE;
               rsp_valid_s = 1'b0;
               cmd_ready_s = 1'b1;
            end else begin
               state_s     = RESP;
               rsp_valid_s = 1'b1;
            end
         end
         default: begin
            state_s     = IDLE;
            rsp_valid_s = 1'b0;
         end
      endcase
`ifndef APB3_MASTER_TIMEOUT_EN
      rsp_timeout_s = 1'b0;
`endif
      busy_s = (state_s != IDLE);
   end

   // State and output registers; async reset clears everything.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= IDLE;
         cmd_ready   <= 1'b0;
         busy        <= 1'b0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PADDR       <= {ADDR_WIDTH{1'b0}};
         PWRITE      <= 1'b0;
         PWDATA      <= {DATA_WIDTH{1'b0}};
         rsp_valid   <= 1'b0;
         rsp_rdata   <= {DATA_WIDTH{1'b0}};
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
`ifdef APB3_MASTER_TIMEOUT_EN
         cnt_r       <= {CNT_W{1'b0}};
`endif
      end else begin
         state_r     <= state_s;
         cmd_ready   <= cmd_ready_s;
         busy        <= busy_s;
         PSEL        <= psel_s;
         PENABLE     <= penable_s;
         PADDR       <= paddr_s;
         PWRITE      <= pwrite_s;
         PWDATA      <= pwdata_s;
         rsp_valid   <= rsp_valid_s;
         rsp_rdata   <= rsp_rdata_s;
         rsp_err     <= rsp_err_s;
         rsp_timeout <= rsp_timeout_s;
`ifdef APB3_MASTER_TIMEOUT_EN
         cnt_r       <= cnt_s;
`endif
      end
   end

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Directed self-checking bench for apb3_master_bridge (TIMEOUT_CYCLES = 8).
module tb_apb3_master_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
   logic [31:0] rsp_rdata;
   logic [11:0] PADDR;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERROR;
   logic [31:0] PWDATA, PRDATA;

   int errors = 0;
   int checks = 0;

   apb3_master_bridge #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERROR(PSLVERROR)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'h000;
      cmd_wdata = 32'h0; rsp_ready = 1'b0; PRDATA = 32'h0; PREADY = 1'b0; PSLVERROR = 1'b0;
      tick(); tick();
      chk("rst_psel", PSEL, 1'b0);
      chk("rst_penable", PENABLE, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      resetn = 1'b1;
      tick();
      chk("idle_cmd_ready", cmd_ready, 1'b1);

      // write 0x004 <= 0x1, zero wait states
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h004; cmd_wdata = 32'h1;
      PREADY = 1'b1; PRDATA = 32'hDEADBEEF;
      tick();
      cmd_valid = 1'b0;
      chk("wr_setup_psel", PSEL, 1'b1);
      chk("wr_setup_penable", PENABLE, 1'b0);
      chk("wr_setup_paddr", PADDR, 12'h004);
      chk("wr_setup_pwrite", PWRITE, 1'b1);
      chk("wr_setup_pwdata", PWDATA, 32'h1);
      chk("wr_setup_cmd_ready", cmd_ready, 1'b0);
      chk("wr_setup_busy", busy, 1'b1);
      tick();
      chk("wr_access_psel", PSEL, 1'b1);
      chk("wr_access_penable", PENABLE, 1'b1);
      chk("wr_access_pwdata", PWDATA, 32'h1);
      tick();
      chk("wr_resp_psel", PSEL, 1'b0);
      chk("wr_resp_penable", PENABLE, 1'b0);
      chk("wr_resp_valid", rsp_valid, 1'b1);
      chk("wr_resp_err", rsp_err, 1'b0);
      chk("wr_resp_rdata", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("wr_done_valid", rsp_valid, 1'b0);
      chk("wr_done_cmd_ready", cmd_ready, 1'b1);
      chk("wr_done_busy", busy, 1'b0);

      // read 0x014, 3 wait states with stray PSLVERROR, then 5 cycles of backpressure
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h014; cmd_wdata = 32'h55;
      PREADY = 1'b0; PSLVERROR = 1'b1; PRDATA = 32'h0;
      tick();
      cmd_valid = 1'b0;
      chk("rd_setup_pwdata", PWDATA, 32'h0);
      chk("rd_setup_pwrite", PWRITE, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("rd_access_penable", PENABLE, 1'b1);
         chk("rd_access_paddr", PADDR, 12'h014);
         chk("rd_access_rsp_valid", rsp_valid, 1'b0);
         if (i == 3) begin
            PREADY = 1'b1; PSLVERROR = 1'b0; PRDATA = 32'hABCD5678;
         end
         tick();
      end
      PREADY = 1'b0; PRDATA = 32'h0;
      chk("rd_resp_valid", rsp_valid, 1'b1);
      chk("rd_resp_rdata", rsp_rdata, 32'hABCD5678);
      chk("rd_resp_err", rsp_err, 1'b0);
      chk("rd_resp_psel", PSEL, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_rsp_valid", rsp_valid, 1'b1);
         chk("bp_rsp_rdata", rsp_rdata, 32'hABCD5678);
         chk("bp_cmd_ready", cmd_ready, 1'b0);
         chk("bp_busy", busy, 1'b1);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rd_done_valid", rsp_valid, 1'b0);

      // read with slave error, next command held on cmd_valid throughout
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020;
      PREADY = 1'b1; PSLVERROR = 1'b1; PRDATA = 32'h12345678;
      tick();
      cmd_write = 1'b1; cmd_addr = 12'h030; cmd_wdata = 32'hA5;
      tick();
      tick();
      PSLVERROR = 1'b0;
      chk("err_rsp_err", rsp_err, 1'b1);
      chk("err_rsp_timeout", rsp_timeout, 1'b0);
      chk("err_rsp_rdata", rsp_rdata, 32'h12345678);
      tick(); tick();
      chk("err_hold_cmd_ready", cmd_ready, 1'b0);
      chk("err_hold_psel", PSEL, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("held_idle_cmd_ready", cmd_ready, 1'b1);
      chk("held_idle_psel", PSEL, 1'b0);
      tick();
      cmd_valid = 1'b0;
      chk("held_setup_psel", PSEL, 1'b1);
      chk("held_setup_paddr", PADDR, 12'h030);
      chk("held_setup_pwdata", PWDATA, 32'hA5);
      tick(); tick();
      chk("held_resp_valid", rsp_valid, 1'b1);
      chk("held_resp_err", rsp_err, 1'b0);
      chk("held_resp_rdata", rsp_rdata, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

`ifdef APB3_MASTER_TIMEOUT_EN
      // PREADY stuck low: abort after 8 ACCESS cycles
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040;
      PREADY = 1'b0; PRDATA = 32'hCAFEF00D;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("to_access_penable", PENABLE, 1'b1);
         tick();
      end
      chk("to_resp_valid", rsp_valid, 1'b1);
      chk("to_resp_err", rsp_err, 1'b1);
      chk("to_resp_timeout", rsp_timeout, 1'b1);
      chk("to_resp_rdata", rsp_rdata, 32'h0);
      chk("to_resp_psel", PSEL, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      // PREADY on the 8th ACCESS cycle completes normally
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("lim_access_penable", PENABLE, 1'b1);
         if (i == 7) PREADY = 1'b1;
         tick();
      end
      PREADY = 1'b0;
      chk("lim_resp_err", rsp_err, 1'b0);
      chk("lim_resp_timeout", rsp_timeout, 1'b0);
      chk("lim_resp_rdata", rsp_rdata, 32'hCAFEF00D);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`else
      // without the timeout feature ACCESS waits indefinitely
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040;
      PREADY = 1'b0; PRDATA = 32'hCAFEF00D;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
         chk("nto_access_penable", PENABLE, 1'b1);
         chk("nto_rsp_valid", rsp_valid, 1'b0);
         tick();
      end
      PREADY = 1'b1;
      tick();
      PREADY = 1'b0;
      chk("nto_resp_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("nto_resp_timeout", rsp_timeout, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`endif

      // async reset during ACCESS, then a normal transfer
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h050; PREADY = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("ar_access_psel", PSEL, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      chk("ar_psel", PSEL, 1'b0);
      chk("ar_penable", PENABLE, 1'b0);
      chk("ar_rsp_valid", rsp_valid, 1'b0);
      chk("ar_busy", busy, 1'b0);
      tick();
      resetn = 1'b1;
      tick();
      chk("ar_idle_cmd_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h008; cmd_wdata = 32'h77; PREADY = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("ar_setup_paddr", PADDR, 12'h008);
      chk("ar_setup_pwdata", PWDATA, 32'h77);
      tick();
      chk("ar_access_penable", PENABLE, 1'b1);
      tick();
      chk("ar_resp_valid", rsp_valid, 1'b1);
      chk("ar_resp_err", rsp_err, 1'b0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("ar_done_cmd_ready", cmd_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
